pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the Gowin rPLL wrapper and runs on the PLL output clock.
- Synchronizes `pll_lock`, qualifies it as stable for a programmable number of cycles, then releases the design-wide synchronous reset.
- Generates the pixel clock-enable for the composite video pipeline.
- On any loss of lock it re-asserts reset and restarts the sequence.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before leaving STABILIZE (>=1).
- RESET_HOLD_CYCLES, 16: cycles `pixel_ce` runs while `sys_reset` is still asserted, before RUN (>=1).
- CE_DIV, 4: `pixel_ce` period in clk cycles (>=1).
- LOSS_COUNT_WIDTH, 8: width of the lock-loss counter.

Ports:
- clk  input  1  PLL output clock (outclk); all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pll_lock  input  1  PLL lock indicator; asynchronous to clk.
- sys_reset  output  1  synchronous active-high reset for downstream video logic.
- running  output  1  high only in RUN.
- pixel_ce  output  1  single-cycle clock-enable pulse every CE_DIV cycles.
- lock_loss_count  output  LOSS_COUNT_WIDTH  saturating count of lock losses seen in RUN.

Behaviour:
- Reset values (cycle after reset sampled high):
  - state=WAIT_LOCK, sync flops=0, stable/hold counters=0, ce divider=0.
  - sys_reset=1, running=0, pixel_ce=0, lock_loss_count=0.
- reset overrides everything, including a mid-sequence or RUN state. It returns to WAIT_LOCK and clears lock_loss_count.
- Synchronizer: 2 flops, lock_s = stage 2. If pll_lock goes high before edge 0, lock_s is high after edge 1 and the state changes at edge 2. So pll_lock high from cycle 0 gives STABILIZE from cycle 3.
- Outputs are decoded from registered state/counters only; no combinational path from pll_lock.
- States:
  - WAIT_LOCK:
    - sys_reset=1, pixel_ce=0, divider held at 0.
    - lock_s=1 → STABILIZE with stable counter cleared.
  - STABILIZE:
    - sys_reset=1, pixel_ce=0.
    - Stable counter increments each cycle while lock_s=1.
    - lock_s=0 → WAIT_LOCK; no loss count.
    - Counter == STABLE_CYCLES-1 with lock_s=1 → HOLD. STABILIZE therefore lasts exactly STABLE_CYCLES cycles.
  - HOLD:
    - sys_reset=1, divider free-runs, pixel_ce active.
    - Hold counter counts RESET_HOLD_CYCLES cycles, then → RUN.
    - lock_s=0 → WAIT_LOCK; no loss count.
  - RUN:
    - sys_reset=0, running=1, pixel_ce active.
    - lock_s=0 → WAIT_LOCK.
    - lock_loss_count increments on that transition and saturates at all-ones.
- Latency:
  - With pll_lock high from cycle 0, the first RUN cycle (sys_reset=0) is cycle 3+STABLE_CYCLES+RESET_HOLD_CYCLES.
  - A lock drop at cycle t gives sys_reset=1 at cycle t+3. The loss is debounced by nothing; a 1-cycle drop that reaches lock_s still resets.
- pixel_ce:
  - Divider counts 0..CE_DIV-1 and wraps.
  - pixel_ce=1 in the cycle after divider==CE_DIV-1, so the first pulse is the CE_DIV-th cycle of HOLD.
  - CE_DIV=1: pixel_ce constantly 1 in HOLD/RUN.
  - Leaving HOLD/RUN for WAIT_LOCK: divider and pixel_ce go to 0 in the same cycle sys_reset reasserts.
- Counter widths: $clog2 of the max count, minimum 1 bit.
- Glitches shorter than one clk period may be missed by the synchronizer; this is accepted.

Optional Feature:
- Macro: PLL_LOCK_LOSS_COUNT_EN.
- Defined: lock_loss_count is implemented as described.
- Undefined: the counter logic is removed and lock_loss_count is tied to 0. All other behaviour is identical.

Test Plan:
1. Parameters STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, CE_DIV=4. Release reset, pll_lock=1 from cycle 0:
   - STABILIZE cycles 3-10, HOLD cycles 11-14.
   - RUN from cycle 15: sys_reset 1→0 at cycle 15, running=1.
   - pixel_ce first pulse at cycle 14, then every 4 cycles.
2. Same parameters, pll_lock pulled low for 3 cycles at cycle 7 (in STABILIZE) → back to WAIT_LOCK, sys_reset stays 1, lock_loss_count=0. The sequence restarts and RUN is reached 15 cycles after lock returns.
3. In RUN, drop pll_lock at cycle t for 2 cycles:
   - sys_reset=1, running=0, pixel_ce=0 at cycle t+3.
   - lock_loss_count=1.
   - Re-lock → RUN again after the full sequence.
4. LOSS_COUNT_WIDTH=2, force 5 lock losses from RUN → count reads 1,2,3,3,3. Repeat with PLL_LOCK_LOSS_COUNT_EN undefined → count reads 0 throughout.
5. Assert reset for 1 cycle while in RUN with lock_loss_count=2:
   - Next cycle: sys_reset=1, running=0, pixel_ce=0, count=0.
   - With pll_lock still high, RUN is re-entered 3+STABLE_CYCLES+RESET_HOLD_CYCLES cycles after reset drops.
6. CE_DIV=1 → pixel_ce=1 every cycle of HOLD/RUN and 0 in WAIT_LOCK/STABILIZE.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Lock qualification and reset release sequencer behind the rPLL, plus the pixel clock-enable divider.
// Optional lock-loss counter is enabled by defining PLL_LOCK_LOSS_COUNT_EN.
module pll_reset_sequencer #(
  parameter int STABLE_CYCLES     = 1024,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int CE_DIV            = 4,
  parameter int LOSS_COUNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pll_lock,
  output logic                        sys_reset,
  output logic                        running,
  output logic                        pixel_ce,
  output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count
);

  localparam int STABLE_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HOLD_W   = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam int DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [STABLE_W-1:0] STABLE_ONE  = STABLE_W'(1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_ONE    = HOLD_W'(1);
  localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE     = DIV_W'(1);
  localparam logic [LOSS_COUNT_WIDTH-1:0] LOSS_ONE = LOSS_COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic                        sync1_q, sync1_d;
  logic                        sync2_q, sync2_d;
  logic [STABLE_W-1:0]         stable_cnt_q, stable_cnt_d;
  logic [HOLD_W-1:0]           hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic                        sys_reset_q, sys_reset_d;
  logic                        running_q, running_d;
  logic                        pixel_ce_q, pixel_ce_d;
  logic [LOSS_COUNT_WIDTH-1:0] loss_cnt_q, loss_cnt_d;
  logic                        lock_s;
  logic                        active_q, active_d;

  assign lock_s = sync2_q;

  always_comb begin
    sync1_d      = pll_lock;
    sync2_d      = sync1_q;
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    hold_cnt_d   = hold_cnt_q;

    case (state_q)
      WAIT_LOCK: begin
        stable_cnt_d = '0;
        hold_cnt_d   = '0;
        if (lock_s) begin
          state_d = STABILIZE;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (stable_cnt_q == STABLE_LAST) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end else begin
          stable_cnt_d = stable_cnt_q + STABLE_ONE;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    active_q = (state_q == HOLD) || (state_q == RUN);
    active_d = (state_d == HOLD) || (state_d == RUN);
    if (active_q && active_d) begin
      div_d = (div_q == DIV_LAST) ? '0 : (div_q + DIV_ONE);
    end else begin
      div_d = '0;
    end
    pixel_ce_d  = active_d && (div_d == DIV_LAST);
    sys_reset_d = (state_d != RUN);
    running_d   = (state_d == RUN);

`ifdef PLL_LOCK_LOSS_COUNT_EN
    if ((state_q == RUN) && !lock_s && (loss_cnt_q != {LOSS_COUNT_WIDTH{1'b1}})) begin
      loss_cnt_d = loss_cnt_q + LOSS_ONE;
    end else begin
      loss_cnt_d = loss_cnt_q;
    end
`else
    loss_cnt_d = '0;
`endif
  end

  // Single state register for the sequencer, its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_cnt_q <= '0;
      hold_cnt_q   <= '0;
      div_q        <= '0;
      sys_reset_q  <= 1'b1;
      running_q    <= 1'b0;
      pixel_ce_q   <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_cnt_q <= stable_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      div_q        <= div_d;
      sys_reset_q  <= sys_reset_d;
      running_q    <= running_d;
      pixel_ce_q   <= pixel_ce_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign sys_reset       = sys_reset_q;
  assign running         = running_q;
  assign pixel_ce        = pixel_ce_q;
  assign lock_loss_count = loss_cnt_q;

endmodule
